// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared FSM state type and counter-width helper for spi_txn_arbiter
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SEND,
    WAIT_RX,
    CS_HOLD,
    DONE
  } state_t;

  // Bits needed to count from 0 up to the larger of two cycle limits
  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: combinational round-robin pick; the search starts one past the pointer
module spi_rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               valid_o
);

  logic [PTR_W-1:0] k;

  // walk from the farthest candidate to the nearest so the nearest active request wins
  always_comb begin
    gnt_o = '0;
    k = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = PTR_W'((int'(ptr_i) + i) % NUM_REQ);
      if (req_i[k]) gnt_o = NUM_REQ'(1) << k;
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: shares one byte-level spi_master between NUM_REQ requesters, one
// chip-selected burst per grant, round-robin between bursts, CS setup/hold owned here.
// Define SPI_ARB_WDOG_EN to abort bursts whose requester stalls for WDOG_CLKS in SEND.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int LEN_W         = 8,
  parameter int CS_SETUP_CLKS = 2,
  parameter int CS_HOLD_CLKS  = 2,
  parameter int WDOG_CLKS     = 255
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic [NUM_REQ-1:0]       i_Req,
  input  logic [NUM_REQ*LEN_W-1:0] i_Req_Len,
  input  logic [NUM_REQ*8-1:0]     i_Req_Byte,
  input  logic [NUM_REQ-1:0]       i_Req_Byte_Valid,
  output logic [NUM_REQ-1:0]       o_Req_Byte_Ready,
  output logic [7:0]               o_Rx_Byte,
  output logic [NUM_REQ-1:0]       o_Rx_DV,
  output logic [NUM_REQ-1:0]       o_Grant,
  output logic [NUM_REQ-1:0]       o_Done,
  output logic [NUM_REQ-1:0]       o_Err,
  output logic [NUM_REQ-1:0]       o_SPI_CS_n,
  output logic [7:0]               o_TX_Byte,
  output logic                     o_TX_DV,
  input  logic                     i_TX_Ready,
  input  logic [7:0]               i_RX_Byte,
  input  logic                     i_RX_DV
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_w(CS_SETUP_CLKS, CS_HOLD_CLKS);

  state_t               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [PTR_W-1:0]     g_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [LEN_W-1:0]     rem_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_REQ-1:0]   cs_n_q;
  logic [7:0]           tx_byte_q;
  logic                 tx_dv_q;
  logic [NUM_REQ-1:0]   rdy_q;
  logic [7:0]           rx_byte_q;
  logic [NUM_REQ-1:0]   rx_dv_q;
  logic [NUM_REQ-1:0]   done_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic                 arb_valid;
  logic [PTR_W-1:0]     gnt_idx_d;
  logic [LEN_W-1:0]     len_d;
  logic [7:0]           byte_d;
  logic                 valid_d;

`ifdef SPI_ARB_WDOG_EN
  localparam int WDOG_W = cnt_w(WDOG_CLKS, 1);
  logic [WDOG_W-1:0]    wdog_q;
  logic                 err_q;
  logic [NUM_REQ-1:0]   err_out_q;
  assign o_Err = err_out_q;
`else
  assign o_Err = '0;
`endif

  spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (i_Req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  // index of the arbiter's pick and the granted requester's length, byte and valid
  always_comb begin
    gnt_idx_d = '0;
    for (int i = 0; i < NUM_REQ; i++) if (arb_gnt[i]) gnt_idx_d = PTR_W'(i);
    len_d   = i_Req_Len[int'(gnt_idx_d)*LEN_W +: LEN_W];
    byte_d  = i_Req_Byte[int'(g_q)*8 +: 8];
    valid_d = i_Req_Byte_Valid[g_q];
  end

  // burst FSM with registered outputs; CS falls on grant and rises on entry to DONE
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      g_q       <= '0;
      ptr_q     <= PTR_W'(NUM_REQ-1);
      rem_q     <= '0;
      cnt_q     <= '0;
      cs_n_q    <= '1;
      tx_byte_q <= '0;
      tx_dv_q   <= 1'b0;
      rdy_q     <= '0;
      rx_byte_q <= '0;
      rx_dv_q   <= '0;
      done_q    <= '0;
`ifdef SPI_ARB_WDOG_EN
      wdog_q    <= '0;
      err_q     <= 1'b0;
      err_out_q <= '0;
`endif
    end else begin
      tx_dv_q <= 1'b0;
      rdy_q   <= '0;
      rx_dv_q <= '0;
      done_q  <= '0;
`ifdef SPI_ARB_WDOG_EN
      err_out_q <= '0;
`endif
      case (state_q)
        IDLE: if (arb_valid) begin
          grant_q <= arb_gnt;
          g_q     <= gnt_idx_d;
          rem_q   <= len_d;
          cnt_q   <= '0;
`ifdef SPI_ARB_WDOG_EN
          wdog_q  <= '0;
          err_q   <= 1'b0;
`endif
          if (len_d == '0) state_q <= DONE;
          else begin
            cs_n_q  <= ~arb_gnt;
            state_q <= (CS_SETUP_CLKS > 1) ? CS_SETUP : SEND;
          end
        end
        CS_SETUP: if (cnt_q == CNT_W'(CS_SETUP_CLKS-2)) begin
          cnt_q   <= '0;
          state_q <= SEND;
        end else cnt_q <= cnt_q + CNT_W'(1);
        SEND: if (valid_d && i_TX_Ready) begin
          tx_dv_q   <= 1'b1;
          tx_byte_q <= byte_d;
          rdy_q     <= grant_q;
          state_q   <= WAIT_RX;
`ifdef SPI_ARB_WDOG_EN
          wdog_q    <= '0;
`endif
        end
`ifdef SPI_ARB_WDOG_EN
        else if (!valid_d) begin
          if (wdog_q == WDOG_W'(WDOG_CLKS-1)) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= CS_HOLD;
          end else wdog_q <= wdog_q + WDOG_W'(1);
        end
`endif
        WAIT_RX: if (i_RX_DV) begin
          rx_byte_q <= i_RX_Byte;
          rx_dv_q   <= grant_q;
          rem_q     <= rem_q - LEN_W'(1);
          cnt_q     <= '0;
          state_q   <= (rem_q == LEN_W'(1)) ? CS_HOLD : SEND;
        end
        CS_HOLD: if (cnt_q == CNT_W'(CS_HOLD_CLKS-1)) begin
          cs_n_q  <= '1;
          state_q <= DONE;
        end else cnt_q <= cnt_q + CNT_W'(1);
        DONE: begin
          done_q  <= grant_q;
          grant_q <= '0;
          ptr_q   <= g_q;
          state_q <= IDLE;
`ifdef SPI_ARB_WDOG_EN
          err_out_q <= err_q ? grant_q : '0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_Req_Byte_Ready = rdy_q;
  assign o_Rx_Byte        = rx_byte_q;
  assign o_Rx_DV          = rx_dv_q;
  assign o_Grant          = grant_q;
  assign o_Done           = done_q;
  assign o_SPI_CS_n       = cs_n_q;
  assign o_TX_Byte        = tx_byte_q;
  assign o_TX_DV          = tx_dv_q;

endmodule
